buffered_data_splitter: RTL and testbench
=========================================

# buffered_data_splitter

Per-node elastic successor to the registered NoC data splitter. Splits the flattened NoC ejection bus into `NODE_PER_ROW*NODE_PER_COL` independent channels. Each channel has a `DEPTH`-entry FIFO, a valid/ready output handshake, almost-full backpressure toward the NoC and sticky overflow reporting. Sits between the flattened-butterfly ejection ports and per-node consumers that can stall.

## Interface
- `DATA_W`, 8, payload bits per channel
- `NODE_PER_ROW`, 4, nodes per row
- `NODE_PER_COL`, 4, nodes per column; N = `NODE_PER_ROW*NODE_PER_COL` channels
- `DEPTH`, 4, FIFO entries per channel; power of two, ≥2
- `AF_MARGIN`, 1, almost-full asserts when occupancy ≥ `DEPTH-AF_MARGIN`; range 0..`DEPTH-1`
- `CNT_W`, 8, drop-counter width (only with macro)

Ports:
- `clk` in 1, single clock, all logic on rising edge
- `rst` in 1, synchronous, active-low reset
- `valid_i_NoC` in [0:N-1], per-channel input beat valid; no input ready
- `data_i_NoC` in [0:DATA_W*N-1], channel i at `[i*DATA_W +: DATA_W]`
- `off_sigs_i_NoC` in [0:N-1], channel disable
- `ready_i_NoC` in [0:N-1], consumer ready per channel
- `valid_o_NoC` out [0:N-1], head entry valid
- `data_o_NoC` out [0:DATA_W*N-1], head entry, same packing as input
- `off_sigs_o_NoC` out [0:N-1], `off_sigs_i_NoC` delayed one cycle
- `afull_o_NoC` out [0:N-1], registered almost-full, backpressure to NoC
- `ovf_o_NoC` out [0:N-1], sticky overflow flag
- `drop_cnt_o_NoC` out [0:CNT_W*N-1], per-channel drop count, only with `SPLITTER_DROP_CNT_EN`

## Operation
- Channels are fully independent. Nothing is shared except `clk` and `rst`.
- Pop: `valid_o_NoC[i] && ready_i_NoC[i]` at a rising edge.
- Push attempt: `valid_i_NoC[i] && !off_sigs_i_NoC[i]`.
- Push is accepted when occupancy < `DEPTH`, or when occupancy = `DEPTH` and a pop occurs in the same cycle. Full with simultaneous pop gives push+pop, and occupancy stays `DEPTH`.
- A push attempt on a full channel with no pop is a drop:
  - the beat is discarded and FIFO contents are unchanged;
  - `ovf_o_NoC[i]` sets and stays set until reset.
- Push while off: a beat with `off_sigs_i_NoC[i]`=1 is ignored silently. It is not a drop and does not set overflow. The FIFO still drains normally while off.
- Storage:
  - circular buffer with read and write pointers of log2(`DEPTH`) bits, wrapping `DEPTH-1`→0;
  - occupancy counter of log2(`DEPTH`)+1 bits;
  - full and empty are derived from the counter, not from pointer equality.
- Output (first-word fall-through): `valid_o_NoC[i]` = occupancy≠0. `data_o_NoC` channel i = the entry at the read pointer.
- While empty, `data_o_NoC` holds the last popped value (0 after reset). It never shows unwritten storage.
- `afull_o_NoC[i]` is registered from the next-state occupancy.

## Timing
- Reset (`rst`=0 at an edge): all pointers/counters 0; `valid_o_NoC`=0; `data_o_NoC`=0; `off_sigs_o_NoC`=0; `afull_o_NoC`=0 (or 1 when `DEPTH-AF_MARGIN`=0); `ovf_o_NoC`=0; drop counters 0.
- Reset mid-operation: all stored beats are discarded. Any push or pop in the reset cycle is ignored.
- Latency into an empty channel: a beat pushed at edge k shows `valid_o_NoC`=1 and its data after edge k, i.e. 1 cycle, same as the predecessor.
- Throughput: 1 beat/cycle/channel when the consumer is ready.
- Ordering: pop at edge k presents the next entry after edge k, with no bubble.
- `off_sigs_o_NoC`: exactly 1-cycle delay, unaffected by FIFO state.
- `afull_o_NoC`: valid after the same edge that changes occupancy. The NoC sees it one cycle after the causing push, so `AF_MARGIN` ≥ NoC reaction latency.
- `ovf_o_NoC`: rises after the edge of the first drop.

## Configuration
- `SPLITTER_DROP_CNT_EN` defined:
  - adds port `drop_cnt_o_NoC`;
  - each channel has a `CNT_W`-bit counter that increments on every drop;
  - the counter saturates at 2^`CNT_W`-1 and is reset to 0.
- Not defined: the port and counters are absent; `ovf_o_NoC` is the only drop indication.

## Test plan
- Reset: hold `rst`=0 two cycles with random inputs → all outputs 0, `valid_o_NoC`=0.
- Latency and streaming:
  - stimulus: channel 5 pushes 0x11,0x22,0x33 on consecutive edges, `ready_i`=1;
  - response: `valid_o[5]`=1 from the cycle after the first edge, data 0x11,0x22,0x33 on consecutive cycles, no bubbles;
  - other channels stay idle.
- Full, stall and almost-full (`DEPTH`=4, `AF_MARGIN`=1, `ready_i[0]`=0):
  - push 0xA0..0xA4 → `afull_o[0]`=1 after the 3rd push;
  - 0xA4 is dropped and `ovf_o[0]`=1;
  - with the macro, drop count = 1;
  - then `ready_i[0]`=1 → outputs 0xA0..0xA3 only.
- Full with simultaneous push+pop: at occupancy 4, push 0xB5 while popping → 0xB5 is accepted, `ovf_o` stays 0, occupancy stays 4, pointer wraps correctly.
- Off channel:
  - `off_sigs_i[3]`=1 with `valid_i[3]`=1 for 10 cycles → nothing is stored and `ovf_o[3]`=0;
  - `off_sigs_o[3]` follows with a 1-cycle delay;
  - entries already stored in channel 3 still drain.
- Reset mid-operation: reset with 3 entries stored → `valid_o`=0 after the edge and the FIFO is empty afterward. With the macro, drop counting saturates at 255 for `CNT_W`=8 after 300 drops.

Source files
------------

// File: rtl/buffered_data_splitter_if.sv
// Ejection-side and consumer-side bundle for buffered_data_splitter.
// drop_cnt_o_NoC and CNT_W exist only when SPLITTER_DROP_CNT_EN is defined.
interface buffered_data_splitter_if #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned NODE_PER_ROW = 4,
   parameter int unsigned NODE_PER_COL = 4
`ifdef SPLITTER_DROP_CNT_EN
   ,
   parameter int unsigned CNT_W        = 8
`endif
);
   localparam int unsigned N = NODE_PER_ROW * NODE_PER_COL;

   logic [0:N-1]        valid_i_NoC;
   logic [0:DATA_W*N-1] data_i_NoC;
   logic [0:N-1]        off_sigs_i_NoC;
   logic [0:N-1]        ready_i_NoC;
   logic [0:N-1]        valid_o_NoC;
   logic [0:DATA_W*N-1] data_o_NoC;
   logic [0:N-1]        off_sigs_o_NoC;
   logic [0:N-1]        afull_o_NoC;
   logic [0:N-1]        ovf_o_NoC;
`ifdef SPLITTER_DROP_CNT_EN
   logic [0:CNT_W*N-1]  drop_cnt_o_NoC;
`endif

   modport master (
      output valid_i_NoC, data_i_NoC, off_sigs_i_NoC, ready_i_NoC,
      input  valid_o_NoC, data_o_NoC, off_sigs_o_NoC, afull_o_NoC, ovf_o_NoC
`ifdef SPLITTER_DROP_CNT_EN
      , input drop_cnt_o_NoC
`endif
   );

   modport slave (
      input  valid_i_NoC, data_i_NoC, off_sigs_i_NoC, ready_i_NoC,
      output valid_o_NoC, data_o_NoC, off_sigs_o_NoC, afull_o_NoC, ovf_o_NoC
`ifdef SPLITTER_DROP_CNT_EN
      , output drop_cnt_o_NoC
`endif
   );
endinterface

// File: rtl/buffered_data_splitter.sv
// Splits the flattened NoC ejection bus into independent per-node FIFO channels.
// Optional per-channel saturating drop counters under SPLITTER_DROP_CNT_EN.
module buffered_data_splitter #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned NODE_PER_ROW = 4,
   parameter int unsigned NODE_PER_COL = 4,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned AF_MARGIN    = 1
`ifdef SPLITTER_DROP_CNT_EN
   ,
   parameter int unsigned CNT_W        = 8
`endif
) (
   input  logic                     clk,
   input  logic                     rst,
   buffered_data_splitter_if.slave  bus
);
   localparam int unsigned N     = NODE_PER_ROW * NODE_PER_COL;
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CW    = AW + 1;
   localparam int unsigned AF_TH = DEPTH - AF_MARGIN;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [CW-1:0] AF_LVL = CW'(AF_TH);
   localparam logic AF_RST = (AF_TH == 0);

   logic [0:N-1]        valid_vec;
   logic [0:N-1]        afull_vec;
   logic [0:N-1]        ovf_vec;
   logic [0:DATA_W*N-1] data_vec;
   logic [0:N-1]        off_q;
`ifdef SPLITTER_DROP_CNT_EN
   logic [0:CNT_W*N-1]  dcnt_vec;
`endif

   // Channel-disable pass-through, independent of FIFO state
   always_ff @(posedge clk) begin
      if (!rst) off_q <= '0;
      else      off_q <= bus.off_sigs_i_NoC;
   end

   for (genvar i = 0; i < int'(N); i++) begin : g_ch
      logic [DATA_W-1:0] mem_q [DEPTH];
      logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
      logic [CW-1:0]     cnt_q, cnt_d;
      logic [DATA_W-1:0] head_q, head_d, din;
      logic              valid_q, afull_q, ovf_q;
      logic              pop, push_try, push_acc, drop;

      // Handshake decode and next-state occupancy/pointers
      always_comb begin
         din      = bus.data_i_NoC[i*DATA_W +: DATA_W];
         pop      = valid_q && bus.ready_i_NoC[i];
         push_try = bus.valid_i_NoC[i] && !bus.off_sigs_i_NoC[i];
         push_acc = push_try && ((cnt_q != FULL) || pop);
         drop     = push_try && !push_acc;
         rd_d     = pop      ? rd_q + AW'(1) : rd_q;
         wr_d     = push_acc ? wr_q + AW'(1) : wr_q;
         cnt_d    = cnt_q + CW'(push_acc) - CW'(pop);
      end

      // Next head: a beat written this edge may land directly at the new read slot
      always_comb begin
         head_d = head_q;
         if (cnt_d != '0) begin
            head_d = (push_acc && (wr_q == rd_d)) ? din : mem_q[rd_d];
         end
      end

      always_ff @(posedge clk) begin
         if (!rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
            afull_q <= AF_RST;
            ovf_q   <= 1'b0;
         end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            valid_q <= (cnt_d != '0);
            afull_q <= (cnt_d >= AF_LVL);
            ovf_q   <= ovf_q || drop;
         end
      end

      // Storage needs no reset; only slots below occupancy are ever shown
      always_ff @(posedge clk) begin
         if (rst && push_acc) mem_q[wr_q] <= din;
      end

      assign valid_vec[i]                    = valid_q;
      assign afull_vec[i]                    = afull_q;
      assign ovf_vec[i]                      = ovf_q;
      assign data_vec[i*DATA_W +: DATA_W]    = head_q;

`ifdef SPLITTER_DROP_CNT_EN
      logic [CNT_W-1:0] dcnt_q, dcnt_d;

      // Saturating drop counter
      always_comb begin
         dcnt_d = dcnt_q;
         if (drop && (dcnt_q != '1)) dcnt_d = dcnt_q + CNT_W'(1);
      end

      always_ff @(posedge clk) begin
         if (!rst) dcnt_q <= '0;
         else      dcnt_q <= dcnt_d;
      end

      assign dcnt_vec[i*CNT_W +: CNT_W] = dcnt_q;
`endif
   end

   assign bus.valid_o_NoC    = valid_vec;
   assign bus.data_o_NoC     = data_vec;
   assign bus.off_sigs_o_NoC = off_q;
   assign bus.afull_o_NoC    = afull_vec;
   assign bus.ovf_o_NoC      = ovf_vec;
`ifdef SPLITTER_DROP_CNT_EN
   assign bus.drop_cnt_o_NoC = dcnt_vec;
`endif

endmodule

// File: tb/tb_buffered_data_splitter.sv
// Self-checking bench for buffered_data_splitter: directed scenarios plus random
// traffic, every cycle compared against a queue-based per-channel model.
module tb_buffered_data_splitter;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned NPR       = 4;
   localparam int unsigned NPC       = 4;
   localparam int unsigned N         = NPR * NPC;
   localparam int unsigned DEPTH     = 4;
   localparam int unsigned AF_MARGIN = 1;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned DROP_MAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

`ifdef SPLITTER_DROP_CNT_EN
   buffered_data_splitter_if #(.DATA_W(DATA_W), .NODE_PER_ROW(NPR), .NODE_PER_COL(NPC),
                               .CNT_W(CNT_W)) bus ();
   buffered_data_splitter #(.DATA_W(DATA_W), .NODE_PER_ROW(NPR), .NODE_PER_COL(NPC),
                            .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN), .CNT_W(CNT_W))
      dut (.clk(clk), .rst(rst), .bus(bus));
`else
   buffered_data_splitter_if #(.DATA_W(DATA_W), .NODE_PER_ROW(NPR), .NODE_PER_COL(NPC)) bus ();
   buffered_data_splitter #(.DATA_W(DATA_W), .NODE_PER_ROW(NPR), .NODE_PER_COL(NPC),
                            .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN))
      dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   // Reference model: one queue per channel plus sticky/last-value state
   logic [DATA_W-1:0] mq [N][$];
   logic [DATA_W-1:0] m_last [N];
   bit                m_ovf [N];
   int unsigned       m_drops [N];
   logic [0:N-1]      m_off;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < int'(N); i++) begin
         if (!rst) begin
            mq[i].delete();
            m_last[i]  = '0;
            m_ovf[i]   = 1'b0;
            m_drops[i] = 0;
         end else begin
            bit do_pop;
            bit do_try;
            do_pop = (mq[i].size() != 0) && bus.ready_i_NoC[i];
            do_try = bus.valid_i_NoC[i] && !bus.off_sigs_i_NoC[i];
            if (do_pop) m_last[i] = mq[i].pop_front();
            if (do_try) begin
               if (mq[i].size() < int'(DEPTH)) mq[i].push_back(bus.data_i_NoC[i*DATA_W +: DATA_W]);
               else begin
                  m_ovf[i] = 1'b1;
                  if (m_drops[i] < DROP_MAX) m_drops[i]++;
               end
            end
         end
      end
      m_off = rst ? bus.off_sigs_i_NoC : '0;
   endtask

   task automatic check_all();
      logic [0:N-1]        ev, ea, eo;
      logic [0:DATA_W*N-1] ed;
      logic [0:CNT_W*N-1]  ec;
      for (int i = 0; i < int'(N); i++) begin
         ev[i] = (mq[i].size() != 0);
         ea[i] = (mq[i].size() >= int'(DEPTH - AF_MARGIN));
         eo[i] = m_ovf[i];
         ed[i*DATA_W +: DATA_W] = (mq[i].size() != 0) ? mq[i][0] : m_last[i];
         ec[i*CNT_W +: CNT_W]   = CNT_W'(m_drops[i]);
      end
      check_eq("valid_o",    256'(bus.valid_o_NoC),    256'(ev));
      check_eq("data_o",     256'(bus.data_o_NoC),     256'(ed));
      check_eq("afull_o",    256'(bus.afull_o_NoC),    256'(ea));
      check_eq("ovf_o",      256'(bus.ovf_o_NoC),      256'(eo));
      check_eq("off_sigs_o", 256'(bus.off_sigs_o_NoC), 256'(m_off));
`ifdef SPLITTER_DROP_CNT_EN
      check_eq("drop_cnt_o", 256'(bus.drop_cnt_o_NoC), 256'(ec));
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
      @(negedge clk);
   endtask

   task automatic idle_in();
      bus.valid_i_NoC    = '0;
      bus.data_i_NoC     = '0;
      bus.off_sigs_i_NoC = '0;
      bus.ready_i_NoC    = '1;
   endtask

   task automatic push_beat(input int ch, input logic [DATA_W-1:0] d);
      bus.valid_i_NoC[ch] = 1'b1;
      bus.data_i_NoC[ch*DATA_W +: DATA_W] = d;
   endtask

   function automatic logic [DATA_W-1:0] head_of(input int ch);
      return bus.data_o_NoC[ch*DATA_W +: DATA_W];
   endfunction

   initial begin
      // Reset with random inputs
      rst = 1'b0;
      bus.valid_i_NoC    = N'($urandom);
      bus.data_i_NoC     = {$urandom, $urandom, $urandom, $urandom};
      bus.off_sigs_i_NoC = N'($urandom);
      bus.ready_i_NoC    = N'($urandom);
      tick();
      tick();
      check_eq("rst_valid", 256'(bus.valid_o_NoC), 256'(0));
      check_eq("rst_data",  256'(bus.data_o_NoC),  256'(0));
      rst = 1'b1;
      idle_in();
      tick();

      // Latency and streaming on channel 5
      for (int k = 0; k < 3; k++) begin
         idle_in();
         push_beat(5, DATA_W'(8'h11 * (k + 1)));
         tick();
         check_eq("stream_valid5", 256'(bus.valid_o_NoC[5]), 256'(1));
         check_eq("stream_data5",  256'(head_of(5)), 256'(8'h11 * (k + 1)));
      end
      idle_in();
      tick();
      check_eq("stream_empty5", 256'(bus.valid_o_NoC[5]), 256'(0));
      check_eq("stream_hold5",  256'(head_of(5)), 256'(8'h33));

      // Fill channel 0, stall, almost-full and drop
      for (int k = 0; k < 5; k++) begin
         idle_in();
         bus.ready_i_NoC[0] = 1'b0;
         push_beat(0, DATA_W'(8'hA0 + k));
         tick();
         if (k == 2) check_eq("afull0_after3", 256'(bus.afull_o_NoC[0]), 256'(1));
         if (k == 3) check_eq("ovf0_before_drop", 256'(bus.ovf_o_NoC[0]), 256'(0));
      end
      check_eq("ovf0_after_drop", 256'(bus.ovf_o_NoC[0]), 256'(1));
      idle_in();
      for (int k = 0; k < 4; k++) begin
         check_eq("drain0_data", 256'(head_of(0)), 256'(8'hA0 + k));
         tick();
      end
      check_eq("drain0_empty", 256'(bus.valid_o_NoC[0]), 256'(0));

      // Full channel 2 with simultaneous push and pop
      for (int k = 1; k <= 4; k++) begin
         idle_in();
         bus.ready_i_NoC[2] = 1'b0;
         push_beat(2, DATA_W'(8'hB0 + k));
         tick();
      end
      idle_in();
      push_beat(2, 8'hB5);
      tick();
      check_eq("pp_ovf2",   256'(bus.ovf_o_NoC[2]),   256'(0));
      check_eq("pp_afull2", 256'(bus.afull_o_NoC[2]), 256'(1));
      idle_in();
      for (int k = 2; k <= 5; k++) begin
         check_eq("pp_drain2", 256'(head_of(2)), 256'(8'hB0 + k));
         tick();
      end

      // Off channel 3: stored beats drain, new beats ignored
      for (int k = 0; k < 2; k++) begin
         idle_in();
         bus.ready_i_NoC[3] = 1'b0;
         push_beat(3, DATA_W'(8'hC0 + k));
         tick();
      end
      for (int k = 0; k < 10; k++) begin
         idle_in();
         bus.off_sigs_i_NoC[3] = 1'b1;
         push_beat(3, DATA_W'($urandom));
         tick();
         check_eq("off3_delay", 256'(bus.off_sigs_o_NoC[3]), 256'(1));
      end
      check_eq("off3_ovf",   256'(bus.ovf_o_NoC[3]),   256'(0));
      check_eq("off3_empty", 256'(bus.valid_o_NoC[3]), 256'(0));
      idle_in();
      tick();
      check_eq("off3_release", 256'(bus.off_sigs_o_NoC[3]), 256'(0));

      // Reset mid-operation with 3 entries in channel 6
      for (int k = 0; k < 3; k++) begin
         idle_in();
         bus.ready_i_NoC[6] = 1'b0;
         push_beat(6, DATA_W'(8'hD0 + k));
         tick();
      end
      rst = 1'b0;
      push_beat(6, 8'hDF);
      tick();
      check_eq("midrst_valid", 256'(bus.valid_o_NoC), 256'(0));
      rst = 1'b1;
      idle_in();
      tick();
      check_eq("midrst_empty6", 256'(bus.valid_o_NoC[6]), 256'(0));

      // Sustained drops on channel 1 to exercise counter saturation
      for (int k = 0; k < 304; k++) begin
         idle_in();
         bus.ready_i_NoC[1] = 1'b0;
         push_beat(1, DATA_W'(k));
         tick();
      end
`ifdef SPLITTER_DROP_CNT_EN
      check_eq("drop1_sat", 256'(bus.drop_cnt_o_NoC[1*CNT_W +: CNT_W]), 256'(DROP_MAX));
`endif
      check_eq("drop1_ovf", 256'(bus.ovf_o_NoC[1]), 256'(1));

      // Random traffic
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(199) != 0);
         for (int i = 0; i < int'(N); i++) begin
            bus.valid_i_NoC[i]    = ($urandom_range(99) < 55);
            bus.off_sigs_i_NoC[i] = ($urandom_range(99) < 10);
            bus.ready_i_NoC[i]    = ($urandom_range(99) < 60);
            bus.data_i_NoC[i*DATA_W +: DATA_W] = DATA_W'($urandom);
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
